data_memory_ctrl: RTL and testbench

Parametrised data memory with a valid/ready request port, byte/halfword/word access with sign or zero extension, and a registered read path. It zero-clears its array through a hardware sweep after reset and flags misaligned or out-of-range accesses. It sits between the CPU load/store stage and the data array and replaces the single-cycle word-only data memory.

---
 rtl/data_memory_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/data_memory_ctrl.sv | 120 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared encodings, FSM states and lane-mask helper for the data memory
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Byte enable for an access of the given size at byte offset addr_lo.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      SIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication/byte enables and load lane extraction/extension
module mem_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_zext,
  input  logic [31:0] ld_word,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_en = lane_mask(st_size, st_lo);

  // Replicating the data lets the byte enable alone pick the target lanes.
  always_comb begin
    wdata = st_data;
    case (st_size)
      SIZE_BYTE: wdata = {4{st_data[7:0]}};
      SIZE_HALF: wdata = {2{st_data[15:0]}};
      default:   wdata = st_data;
    endcase
  end

  assign ld_byte = ld_word[{ld_lo, 3'b000} +: 8];
  assign ld_half = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    load_data = ld_word;
    case (ld_size)
      SIZE_BYTE: load_data = {{24{~ld_zext & ld_byte[7]}}, ld_byte};
      SIZE_HALF: load_data = {{16{~ld_zext & ld_half[15]}}, ld_half};
      default:   load_data = ld_word;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - data memory with valid/ready requests, sub-word access and post-reset clear sweep
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] writeInput,
  output logic        resp_valid,
  output logic [31:0] readResult,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, next_state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, req_fault, misaligned, out_of_range;
  logic [31:0]   wdata, rd_word, load_data;
  logic [3:0]    byte_en;

  logic          resp_fault, resp_load, resp_zext;
  logic [1:0]    resp_size, resp_lo;

  assign word_idx     = address[AW+1:2];
  assign out_of_range = |address[31:AW+2];
  assign misaligned   = ((req_size == SIZE_HALF) && address[0]) ||
                        ((req_size == SIZE_WORD) && (address[1:0] != 2'b00));
  assign req_fault    = (req_size == 2'b11) || misaligned || out_of_range;
  assign accept       = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + AW'(1);
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == AW'(DEPTH_WORDS - 1)) next_state = ST_IDLE;
      end
      ST_IDLE:  req_ready = 1'b1;
      default:  next_state = ST_IDLE;
    endcase
  end

  mem_lane_align u_align (
    .st_size   (req_size),
    .st_lo     (address[1:0]),
    .st_data   (writeInput),
    .wdata     (wdata),
    .byte_en   (byte_en),
    .ld_size   (resp_size),
    .ld_lo     (resp_lo),
    .ld_zext   (resp_zext),
    .ld_word   (rd_word),
    .load_data (load_data)
  );

  // Array is left unreset so it maps onto block RAM; the sweep provides the clear.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_write && !req_fault) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept && !req_write) rd_word <= mem[word_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_load  <= 1'b0;
      resp_size  <= SIZE_BYTE;
      resp_lo    <= 2'b00;
      resp_zext  <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_fault <= req_fault;
        resp_load  <= !req_write && !req_fault;
        resp_size  <= req_size;
        resp_lo    <= address[1:0];
        resp_zext  <= req_unsigned;
      end
    end
  end

  // Extension happens after the registered read; readResult holds until the next response.
  assign readResult = resp_load ? load_data : 32'h0;
  assign fault      = resp_valid && resp_fault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl with DEPTH_WORDS=16
module tb_data_memory_ctrl;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] address, writeInput, readResult;
  logic        resp_valid, fault, busy;

  typedef struct {
    logic [31:0] data;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   run = 0;

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .writeInput   (writeInput),
    .resp_valid   (resp_valid),
    .readResult   (readResult),
    .fault        (fault),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responses are sampled on the falling edge, mid-cycle.
  always @(negedge clock) begin
    if (resp_valid) begin
      run = run + 1;
      check("resp_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("readResult", readResult, e.data);
        check("fault", {31'b0, fault}, {31'b0, e.flt});
      end
    end else begin
      run = 0;
      check("fault_idle", {31'b0, fault}, 32'd0);
    end
  end

  task automatic req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_d, input logic exp_f);
    exp_t e;
    @(negedge clock);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    address      = a;
    writeInput   = d;
    #1;
    check("req_ready", {31'b0, req_ready}, 32'd1);
    e.data = exp_d;
    e.flt  = exp_f;
    sb.push_back(e);
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
  endtask

  task automatic sweep_wait();
    repeat (DEPTH - 1) @(posedge clock);
    #1;
    check("busy_sweep", {31'b0, busy}, 32'd1);
    check("ready_sweep", {31'b0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    check("busy_done", {31'b0, busy}, 32'd0);
    check("ready_done", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    address = '0; writeInput = '0;
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_readResult", readResult, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    sweep_wait();

    req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);
    req(1'b1, 2'b10, 1'b0, 32'h08, 32'h1122_3344, 32'h0, 1'b0);
    req(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AA, 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h1122_AA44, 1'b0);
    req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 32'hFFFF_FFAA, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, 32'h0000_00AA, 1'b0);
    req(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 32'h0000_0011, 1'b0);

    req(1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_8001, 32'h0, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 32'hFFFF_8001, 1'b0);
    req(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 32'h0000_8001, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1);
    req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h8001_0000, 1'b0);

    req(1'b1, 2'b10, 1'b0, 32'h02, 32'hDEAD_BEEF, 32'h0, 1'b1);
    req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b1);
    req(1'b1, 2'b11, 1'b0, 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b1);
    req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1);
    req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);

    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);
    idle();

    req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_F00D, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_0012, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_F00D, 1'b0);
    idle();
    #1;
    check("burst_run", 32'(run), 32'd4);

    req(1'b1, 2'b10, 1'b0, 32'h14, 32'h0000_0055, 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_F00D, 1'b0);
    #2;
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_drop_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_drop_data", readResult, 32'd0);
    check("rst_busy2", {31'b0, busy}, 32'd1);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;

    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midsweep_busy", {31'b0, busy}, 32'd1);
    check("midsweep_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    sweep_wait();

    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
